// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction cache, the data cache, the arbiter
// and the single-ported RAM. The arbiter connects through "master"
// because it is the side that issues RAM accesses. The caches and RAM
// model connect through "slave".
interface mem_arbiter_if;
    // icache side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    // dcache side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    // RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ramerr;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client arbiter in front of a single RAM port.
// The dcache normally has priority. A saturating starvation counter
// hands the port to the icache after STARVE_MAX consecutive dcache
// grants. A dcache access to an even word (daddr[2]==0) locks the port
// for the following word, so a two-word block transfer is not split.
// Read data is passed through combinationally. Only the FSM state, the
// starvation count and the sticky error flag are registered.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic           CLK,
    input logic           nRST,
    mem_arbiter_if.master mem_if
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DGNT  = 2'd1;
    localparam logic [1:0] IGNT  = 2'd2;
    localparam logic [1:0] DLOCK = 2'd3;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [2:0] SCNT_MAX = 3'(STARVE_MAX);

    logic [1:0] state_q, state_d;
    logic [2:0] scnt_q, scnt_d;
    logic       ramerr_q, ramerr_d;

    logic d_req_s;
    logic d_granted_s;
    logic i_granted_s;
    logic ram_access_s;
    logic starve_s;

    // Decode the request, grant and RAM-status qualifiers shared by the blocks below.
    always_comb begin
        d_req_s      = mem_if.dREN | mem_if.dWEN;
        d_granted_s  = (state_q == DGNT) || (state_q == DLOCK);
        i_granted_s  = (state_q == IGNT);
        ram_access_s = (mem_if.ramstate == RAM_ACCESS);
        starve_s     = mem_if.iREN && (scnt_q == SCNT_MAX);
    end

    // Next-state logic. FREE, BUSY and ERROR all hold the grant. ACCESS
    // or a dropped request ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req_s && !starve_s) begin
                    state_d = DGNT;
                end else if (mem_if.iREN) begin
                    state_d = IGNT;
                end else begin
                    state_d = IDLE;
                end
            end
            DGNT: begin
                if (!d_req_s) begin
                    state_d = IDLE;
                end else if (ram_access_s) begin
                    // An even word starts a two-word block, so keep the port.
                    if (mem_if.daddr[2] == 1'b0) begin
                        state_d = DLOCK;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DGNT;
                end
            end
            DLOCK: begin
                if (!d_req_s || ram_access_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DLOCK;
                end
            end
            IGNT: begin
                if (!mem_if.iREN || ram_access_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = IGNT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter: counts dcache grant entries taken while the icache
    // waits. It clears whenever the icache is idle or is finally served.
    always_comb begin
        scnt_d = scnt_q;
        if (!mem_if.iREN) begin
            scnt_d = 3'd0;
        end else if ((state_q == IDLE) && (state_d == IGNT)) begin
            scnt_d = 3'd0;
        end else if ((state_q == IDLE) && (state_d == DGNT) && (scnt_q < SCNT_MAX)) begin
            scnt_d = scnt_q + 3'd1;
        end else begin
            scnt_d = scnt_q;
        end
    end

    // Sticky error flag: set by any ERROR status seen while a client holds the port.
    always_comb begin
        ramerr_d = ramerr_q;
        if ((d_granted_s || i_granted_s) && (mem_if.ramstate == RAM_ERROR)) begin
            ramerr_d = 1'b1;
        end else begin
            ramerr_d = ramerr_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            scnt_q   <= 3'd0;
            ramerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            ramerr_q <= ramerr_d;
        end
    end

    // RAM strobes, address and write data, selected by the current grant.
    always_comb begin
        mem_if.ramREN   = 1'b0;
        mem_if.ramWEN   = 1'b0;
        mem_if.ramaddr  = 32'h0000_0000;
        mem_if.ramstore = 32'h0000_0000;
        case (state_q)
            DGNT, DLOCK: begin
                // A write wins over a read when both are asserted.
                mem_if.ramaddr  = mem_if.daddr;
                mem_if.ramWEN   = mem_if.dWEN;
                mem_if.ramREN   = mem_if.dREN & ~mem_if.dWEN;
                mem_if.ramstore = mem_if.dstore;
            end
            IGNT: begin
                mem_if.ramaddr = mem_if.iaddr;
                mem_if.ramREN  = 1'b1;
            end
            default: begin
                mem_if.ramREN   = 1'b0;
                mem_if.ramWEN   = 1'b0;
                mem_if.ramaddr  = 32'h0000_0000;
                mem_if.ramstore = 32'h0000_0000;
            end
        endcase
    end

    // Client handshakes. A wait drops only in the cycle the granted client,
    // still requesting, sees ACCESS. Load data is the raw RAM bus.
    always_comb begin
        mem_if.dwait  = ~(d_granted_s && d_req_s && ram_access_s);
        mem_if.iwait  = ~(i_granted_s && mem_if.iREN && ram_access_s);
        mem_if.iload  = mem_if.ramload;
        mem_if.dload  = mem_if.ramload;
        mem_if.ramerr = ramerr_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change 1 time unit after a
// rising edge. Checks run before the next edge. ctl() packs
// {ramREN, ramWEN, iwait, dwait}.
module tb_mem_arbiter;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .mem_if (bus)
    );

    function automatic logic [3:0] ctl();
        return {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramstate = 2'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        bus.dREN = 1'b1;
        bus.daddr = 32'h84;
        #2;
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl(), 4'b0011); end
        tests++; if (bus.ramerr !== 1'b0) begin fails++; $display("FAIL reset_ramerr got %b want 0", bus.ramerr); end
        tests++; if (bus.ramaddr !== 32'h0) begin fails++; $display("FAIL reset_ramaddr got %h want 0", bus.ramaddr); end
        tick();
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL reset_held_edge got %b want %b", ctl(), 4'b0011); end
        bus.dREN = 1'b0;
        nRST = 1'b1;
        tick();
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL reset_release_idle got %b want %b", ctl(), 4'b0011); end
    endtask

    // D at 0x80 and I at 0x40 arrive together. D wins. The even word locks
    // the port, then the dcache drops its request. I is served after one
    // IDLE cycle.
    task automatic test_priority();
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        bus.dREN = 1'b1; bus.daddr = 32'h80;
        bus.ramstate = 2'd1;
        #1;
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL prio_idle got %b want %b", ctl(), 4'b0011); end
        tick();
        tests++; if (ctl() !== 4'b1011) begin fails++; $display("FAIL prio_dgnt got %b want %b", ctl(), 4'b1011); end
        tests++; if (bus.ramaddr !== 32'h80) begin fails++; $display("FAIL prio_daddr got %h want 80", bus.ramaddr); end
        tick();
        tests++; if (ctl() !== 4'b1011) begin fails++; $display("FAIL prio_busy_hold got %b want %b", ctl(), 4'b1011); end
        bus.ramstate = 2'd2; bus.ramload = 32'h1234_5678;
        #1;
        tests++; if (ctl() !== 4'b1010) begin fails++; $display("FAIL prio_dcomplete got %b want %b", ctl(), 4'b1010); end
        tests++; if (bus.dload !== 32'h1234_5678) begin fails++; $display("FAIL prio_dload got %h want 12345678", bus.dload); end
        tick();
        bus.dREN = 1'b0; bus.ramstate = 2'd1;
        #1;
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL prio_dlock_ctl got %b want %b", ctl(), 4'b0011); end
        tests++; if (bus.ramaddr !== 32'h80) begin fails++; $display("FAIL prio_dlock_addr got %h want 80", bus.ramaddr); end
        tick();
        tests++; if (bus.ramaddr !== 32'h0) begin fails++; $display("FAIL prio_gap_addr got %h want 0", bus.ramaddr); end
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL prio_gap_ctl got %b want %b", ctl(), 4'b0011); end
        tick();
        tests++; if (ctl() !== 4'b1011) begin fails++; $display("FAIL prio_ignt got %b want %b", ctl(), 4'b1011); end
        tests++; if (bus.ramaddr !== 32'h40) begin fails++; $display("FAIL prio_iaddr got %h want 40", bus.ramaddr); end
        bus.ramstate = 2'd2; bus.ramload = 32'hCAFE_F00D;
        #1;
        tests++; if (ctl() !== 4'b1001) begin fails++; $display("FAIL prio_icomplete got %b want %b", ctl(), 4'b1001); end
        tests++; if (bus.iload !== 32'hCAFE_F00D) begin fails++; $display("FAIL prio_iload got %h want cafef00d", bus.iload); end
        tick();
        idle_inputs();
        #1;
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL prio_end_idle got %b want %b", ctl(), 4'b0011); end
    endtask

    task automatic test_block_write();
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h200;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        bus.ramstate = 2'd1;
        tick();
        tests++; if (ctl() !== 4'b0111) begin fails++; $display("FAIL blk_w0_ctl got %b want %b", ctl(), 4'b0111); end
        tests++; if ({bus.ramaddr, bus.ramstore} !== {32'h100, 32'hDEAD_BEEF}) begin fails++; $display("FAIL blk_w0_bus got %h/%h want 100/deadbeef", bus.ramaddr, bus.ramstore); end
        bus.ramstate = 2'd2;
        #1;
        tests++; if (ctl() !== 4'b0110) begin fails++; $display("FAIL blk_w0_done got %b want %b", ctl(), 4'b0110); end
        tick();
        bus.daddr = 32'h104; bus.dstore = 32'h0BAD_F00D; bus.ramstate = 2'd1;
        #1;
        tests++; if (ctl() !== 4'b0111) begin fails++; $display("FAIL blk_dlock_ctl got %b want %b", ctl(), 4'b0111); end
        tests++; if ({bus.ramaddr, bus.ramstore} !== {32'h104, 32'h0BAD_F00D}) begin fails++; $display("FAIL blk_w1_bus got %h/%h want 104/0badf00d", bus.ramaddr, bus.ramstore); end
        bus.ramstate = 2'd2;
        #1;
        tests++; if (ctl() !== 4'b0110) begin fails++; $display("FAIL blk_w1_done got %b want %b", ctl(), 4'b0110); end
        tick();
        bus.dWEN = 1'b0; bus.ramstate = 2'd0;
        #1;
        tests++; if ({ctl(), bus.ramaddr} !== {4'b0011, 32'h0}) begin fails++; $display("FAIL blk_gap got %b/%h want 0011/0", ctl(), bus.ramaddr); end
        tick();
        tests++; if (bus.ramaddr !== 32'h200) begin fails++; $display("FAIL blk_ignt_addr got %h want 200", bus.ramaddr); end
        bus.ramstate = 2'd2;
        #1;
        tests++; if (ctl() !== 4'b1001) begin fails++; $display("FAIL blk_idone got %b want %b", ctl(), 4'b1001); end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h300;
        bus.dREN = 1'b1; bus.daddr = 32'h84;
        bus.ramstate = 2'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if ({ctl(), bus.ramaddr} !== {4'b1010, 32'h84}) begin fails++; $display("FAIL starve_dgnt%0d got %b/%h want 1010/84", k, ctl(), bus.ramaddr); end
            tick();
            tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL starve_idle%0d got %b want %b", k, ctl(), 4'b0011); end
        end
        tests++; if (dut.scnt_q !== 3'd4) begin fails++; $display("FAIL starve_scnt_sat got %0d want 4", dut.scnt_q); end
        tick();
        tests++; if ({ctl(), bus.ramaddr} !== {4'b1001, 32'h300}) begin fails++; $display("FAIL starve_ignt got %b/%h want 1001/300", ctl(), bus.ramaddr); end
        tests++; if (dut.scnt_q !== 3'd0) begin fails++; $display("FAIL starve_scnt_clr got %0d want 0", dut.scnt_q); end
        tick();
        idle_inputs();
        tick();
        tests++; if (dut.scnt_q !== 3'd0) begin fails++; $display("FAIL starve_scnt_after got %0d want 0", dut.scnt_q); end
    endtask

    task automatic test_rw_conflict();
        tick();
        bus.dREN = 1'b1; bus.dWEN = 1'b1;
        bus.daddr = 32'h0C; bus.dstore = 32'h55AA_55AA;
        bus.ramstate = 2'd1;
        tick();
        tests++; if (ctl() !== 4'b0111) begin fails++; $display("FAIL rw_ctl got %b want %b", ctl(), 4'b0111); end
        tests++; if (bus.ramstore !== 32'h55AA_55AA) begin fails++; $display("FAIL rw_store got %h want 55aa55aa", bus.ramstore); end
        bus.ramstate = 2'd2;
        #1;
        tests++; if (ctl() !== 4'b0110) begin fails++; $display("FAIL rw_done got %b want %b", ctl(), 4'b0110); end
        tick();
        idle_inputs();
        #1;
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL rw_idle got %b want %b", ctl(), 4'b0011); end
    endtask

    task automatic test_error();
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.ramstate = 2'd3;
        #1;
        tests++; if (bus.ramerr !== 1'b0) begin fails++; $display("FAIL err_idle_flag got %b want 0", bus.ramerr); end
        tick();
        tests++; if ({ctl(), bus.ramaddr} !== {4'b1011, 32'h44}) begin fails++; $display("FAIL err_c1 got %b/%h want 1011/44", ctl(), bus.ramaddr); end
        tests++; if (bus.ramerr !== 1'b0) begin fails++; $display("FAIL err_c1_flag got %b want 0", bus.ramerr); end
        tick();
        tests++; if ({ctl(), bus.ramerr} !== {4'b1011, 1'b1}) begin fails++; $display("FAIL err_c2 got %b/%b want 1011/1", ctl(), bus.ramerr); end
        tick();
        tests++; if (ctl() !== 4'b1011) begin fails++; $display("FAIL err_c3 got %b want %b", ctl(), 4'b1011); end
        tick();
        bus.ramstate = 2'd2;
        #1;
        tests++; if ({ctl(), bus.ramerr} !== {4'b1001, 1'b1}) begin fails++; $display("FAIL err_done got %b/%b want 1001/1", ctl(), bus.ramerr); end
        tick();
        idle_inputs();
        #1;
        tests++; if ({ctl(), bus.ramerr} !== {4'b0011, 1'b1}) begin fails++; $display("FAIL err_sticky got %b/%b want 0011/1", ctl(), bus.ramerr); end
        nRST = 1'b0;
        #1;
        tests++; if (bus.ramerr !== 1'b0) begin fails++; $display("FAIL err_rst_clear got %b want 0", bus.ramerr); end
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset_mid();
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h20; bus.ramstate = 2'd1;
        tick();
        tests++; if ({ctl(), bus.ramaddr} !== {4'b1011, 32'h20}) begin fails++; $display("FAIL rstmid_dgnt got %b/%h want 1011/20", ctl(), bus.ramaddr); end
        #2;
        nRST = 1'b0;
        #1;
        tests++; if ({ctl(), bus.ramaddr} !== {4'b0011, 32'h0}) begin fails++; $display("FAIL rstmid_abort got %b/%h want 0011/0", ctl(), bus.ramaddr); end
        tick();
        nRST = 1'b1;
        #1;
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL rstmid_release got %b want %b", ctl(), 4'b0011); end
        tick();
        tests++; if (ctl() !== 4'b1011) begin fails++; $display("FAIL rstmid_regrant got %b want %b", ctl(), 4'b1011); end
        bus.dREN = 1'b0;
        tick();
        tests++; if (ctl() !== 4'b0011) begin fails++; $display("FAIL rstmid_drop got %b want %b", ctl(), 4'b0011); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_block_write();
        test_starvation();
        test_rw_conflict();
        test_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
